// File: rtl/alu_result_stage.sv
// ALU result register stage: one-entry output buffer with HI/LO, flags, sticky overflow and op counter.
// Optional HILO_BYPASS_EN: MULT/DIV results reading HI/LO return the incoming value instead of the old one.
module alu_result_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  FS,
    input  logic [31:0] Y_hi,
    input  logic [31:0] Y_lo,
    input  logic        C,
    input  logic        V,
    input  logic        N,
    input  logic        Z,
    input  logic [1:0]  rd_sel,
    input  logic        clr_sticky,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [3:0]  flags,
    output logic        v_sticky,
    output logic [15:0] op_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [4:0] FS_MULT = 5'h1E;
    localparam logic [4:0] FS_DIV  = 5'h1F;

    state_t      state, state_nxt;
    logic        accept;
    logic        hilo_wr;
    logic [31:0] sel_data;

    assign in_ready  = (state == EMPTY) | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == FULL);
    assign hilo_wr   = (FS == FS_MULT) | (FS == FS_DIV);

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // A drain with a simultaneous accept keeps the buffer full.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL: begin
                if (accept)         state_nxt = FULL;
                else if (out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        sel_data = Y_lo;
        case (rd_sel)
            2'b00: sel_data = Y_lo;
`ifdef HILO_BYPASS_EN
            2'b01: sel_data = hilo_wr ? Y_hi : HI;
            2'b10: sel_data = hilo_wr ? Y_lo : LO;
`else
            2'b01: sel_data = HI;
            2'b10: sel_data = LO;
`endif
            2'b11: sel_data = {28'b0, C, V, N, Z};
            default: sel_data = Y_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= 32'b0;
            HI       <= 32'b0;
            LO       <= 32'b0;
            flags    <= 4'b0;
            v_sticky <= 1'b0;
            op_count <= 16'b0;
        end else begin
            if (accept) begin
                out_data <= sel_data;
                flags    <= {C, V, N, Z};
                op_count <= op_count + 16'd1;
                if (hilo_wr) begin
                    HI <= Y_hi;
                    LO <= Y_lo;
                end
            end
            // Setting on an overflowing accept beats a same-cycle clear.
            if (accept && V)     v_sticky <= 1'b1;
            else if (clr_sticky) v_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: behavioural model compared every cycle plus literal spot checks.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  FS = 5'h0;
    logic [31:0] Y_hi = 32'h0;
    logic [31:0] Y_lo = 32'h0;
    logic        C = 1'b0, V = 1'b0, N = 1'b0, Z = 1'b0;
    logic [1:0]  rd_sel = 2'b00;
    logic        clr_sticky = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [31:0] HI, LO;
    logic [3:0]  flags;
    logic        v_sticky;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    alu_result_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .FS(FS), .Y_hi(Y_hi), .Y_lo(Y_lo), .C(C), .V(V), .N(N), .Z(Z),
        .rd_sel(rd_sel), .clr_sticky(clr_sticky), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .HI(HI), .LO(LO),
        .flags(flags), .v_sticky(v_sticky), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one-entry buffer plus architectural registers.
    bit          started = 0;
    bit          m_valid;
    int unsigned m_data, m_hi, m_lo, m_flags, m_sticky, m_count;

    always @(posedge clk) begin
        bit acc;
        bit mul_div;
        started = 1;
        if (reset) begin
            m_valid = 0; m_data = 0; m_hi = 0; m_lo = 0;
            m_flags = 0; m_sticky = 0; m_count = 0;
        end else begin
            acc     = in_valid && (!m_valid || out_ready);
            mul_div = (FS == 5'd30) || (FS == 5'd31);
            if (acc) begin
                if (rd_sel == 0)      m_data = Y_lo;
                else if (rd_sel == 1) m_data = m_hi;
                else if (rd_sel == 2) m_data = m_lo;
                else                  m_data = C * 8 + V * 4 + N * 2 + Z;
`ifdef HILO_BYPASS_EN
                if (mul_div && rd_sel == 1) m_data = Y_hi;
                if (mul_div && rd_sel == 2) m_data = Y_lo;
`endif
                if (mul_div) begin
                    m_hi = Y_hi;
                    m_lo = Y_lo;
                end
                m_flags = C * 8 + V * 4 + N * 2 + Z;
                m_count = (m_count + 1) % 65536;
                m_valid = 1;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (acc && V)        m_sticky = 1;
            else if (clr_sticky) m_sticky = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data",  out_data,       m_data);
            chk("HI",        HI,             m_hi);
            chk("LO",        LO,             m_lo);
            chk("flags",     32'(flags),     m_flags);
            chk("v_sticky",  32'(v_sticky),  m_sticky);
            chk("op_count",  32'(op_count),  m_count);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] fs, input logic [31:0] hi, input logic [31:0] lo,
                         input logic [1:0] sel, input logic [3:0] cvnz);
        in_valid = 1'b1;
        FS = fs; Y_hi = hi; Y_lo = lo; rd_sel = sel;
        {C, V, N, Z} = cvnz;
    endtask

    initial begin
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // MULT load with plain Y_lo readout
        out_ready = 1'b1;
        drive(5'h1E, 32'h1, 32'h2, 2'b00, 4'h0);
        cyc();
        in_valid = 1'b0;
        chk("t34_out_valid", 32'(out_valid), 32'h1);
        chk("t34_out_data", out_data, 32'h2);
        chk("t34_HI", HI, 32'h1);
        chk("t34_LO", LO, 32'h2);
        chk("t34_op_count", 32'(op_count), 32'h1);

        // HI read while DIV overwrites it
        drive(5'h1E, 32'hA, 32'h0, 2'b00, 4'h0);
        cyc();
        drive(5'h1F, 32'hB, 32'hC, 2'b01, 4'h0);
        cyc();
        in_valid = 1'b0;
`ifdef HILO_BYPASS_EN
        chk("t35_out_data", out_data, 32'hB);
`else
        chk("t35_out_data", out_data, 32'hA);
`endif
        chk("t35_HI", HI, 32'hB);
        // Non-MULT/DIV leaves HI/LO alone
        drive(5'h03, 32'h77, 32'h88, 2'b10, 4'h0);
        cyc();
        in_valid = 1'b0;
        chk("nohilo_out_data", out_data, 32'hC);
        chk("nohilo_HI", HI, 32'hB);
        cyc();

        // Backpressure: second result stalls, then streams through
        out_ready = 1'b0;
        drive(5'h00, 32'h0, 32'h5, 2'b00, 4'h0);
        cyc();
        Y_lo = 32'h6;
        chk("t36_in_ready_stall", 32'(in_ready), 32'h0);
        cyc();
        chk("t36_hold", out_data, 32'h5);
        out_ready = 1'b1;
        #1;
        chk("t36_in_ready_go", 32'(in_ready), 32'h1);
        cyc();
        in_valid = 1'b0;
        chk("t36_next", out_data, 32'h6);
        chk("t36_valid", 32'(out_valid), 32'h1);
        cyc();
        chk("t36_drained", 32'(out_valid), 32'h0);

        // Sticky overflow and flag readout
        drive(5'h02, 32'h0, 32'h0, 2'b11, 4'hD);
        cyc();
        chk("t37_set", 32'(v_sticky), 32'h1);
        chk("t37_flags_data", out_data, 32'hD);
        chk("t37_flags", 32'(flags), 32'hD);
        drive(5'h02, 32'h0, 32'h0, 2'b00, 4'h0);
        cyc();
        chk("t37_keep", 32'(v_sticky), 32'h1);
        drive(5'h02, 32'h0, 32'h0, 2'b00, 4'h4);
        clr_sticky = 1'b1;
        cyc();
        chk("t37_set_wins", 32'(v_sticky), 32'h1);
        in_valid = 1'b0;
        cyc();
        clr_sticky = 1'b0;
        chk("t37_clear", 32'(v_sticky), 32'h0);

        // Counter wrap after 65535 accepts from reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            drive(5'(i), 32'(i * 3), 32'(i), 2'(i), 4'(i >> 2));
            clr_sticky = (i % 7) == 0;
            cyc();
        end
        clr_sticky = 1'b0;
        chk("t38_ffff", 32'(op_count), 32'hFFFF);
        drive(5'h00, 32'h0, 32'h0, 2'b00, 4'h0);
        cyc();
        in_valid = 1'b0;
        chk("t38_wrap", 32'(op_count), 32'h0);
        cyc();

        // Reset while full and stalled
        out_ready = 1'b0;
        drive(5'h1E, 32'h55, 32'h66, 2'b00, 4'h4);
        cyc();
        chk("t39_pre_full", 32'(out_valid), 32'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("t39_out_valid", 32'(out_valid), 32'h0);
        chk("t39_out_data", out_data, 32'h0);
        chk("t39_HI", HI, 32'h0);
        chk("t39_LO", LO, 32'h0);
        chk("t39_flags", 32'(flags), 32'h0);
        chk("t39_sticky", 32'(v_sticky), 32'h0);
        chk("t39_op_count", 32'(op_count), 32'h0);
        chk("t39_in_ready", 32'(in_ready), 32'h1);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock; the one clock for the block.
REQ-002 SHALL have: reset  input  1  reset; synchronous and active-high.
REQ-003 SHALL have: in_valid  input  1  ALU result valid this cycle.
REQ-004 SHALL have: in_ready  output  1  stage can accept a result.
REQ-005 SHALL have: FS  input  5  ALU function select that produced the result.
REQ-006 SHALL have: Y_hi  input  32  ALU high result.
REQ-007 SHALL have: Y_lo  input  32  ALU low result.
REQ-008 SHALL have: C, V, N, Z  input  1 each  ALU status flags.
REQ-009 SHALL have: rd_sel  input  2  output source select: 00 Y_lo, 01 HI, 10 LO, 11 flags.
REQ-010 SHALL have: clr_sticky  input  1  clears the sticky overflow bit.
REQ-011 SHALL have: out_ready  input  1  downstream accepts out_data.
REQ-012 SHALL have: out_valid  output  1  out_data holds a result.
REQ-013 SHALL have: out_data  output  32  registered result.
REQ-014 SHALL have: HI, LO  output  32 each  architectural HI/LO registers.
REQ-015 SHALL have: flags  output  4  last accepted {C,V,N,Z}.
REQ-016 SHALL have: v_sticky  output  1  overflow seen since last clear.
REQ-017 SHALL have: op_count  output  16  accepted-result counter.

Function
REQ-018 SHALL use a two-state output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 SHALL drive in_ready = (state==EMPTY) | out_ready; this is combinational, with no bubble on a continuous stream.
REQ-020 SHALL accept a result when in_valid & in_ready; accept → FULL next cycle.
REQ-021 SHALL go FULL→EMPTY when out_ready with no accept in the same cycle, and SHALL stay FULL on simultaneous drain plus accept.
REQ-022 SHALL hold out_data stable while out_valid & !out_ready.
REQ-023 SHALL load HI<=Y_hi and LO<=Y_lo on accept only when FS==5'h1E (MULT) or FS==5'h1F (DIV); all other FS values leave HI/LO unchanged.
REQ-024 SHALL capture out_data on accept as: rd_sel 00 → Y_lo; 01 → HI; 10 → LO; 11 → {28'b0,C,V,N,Z}.
REQ-025 SHALL, for rd_sel 01/10, read the HI/LO values held before the edge (same-cycle write not visible) unless REQ-033 applies.
REQ-026 SHALL load flags<={C,V,N,Z} on every accept.
REQ-027 SHALL set v_sticky on accept with V=1 and clear it on clr_sticky; set wins when both occur in the same cycle.
REQ-028 SHALL increment op_count by 1 per accept, wrapping FFFF→0000.
REQ-029 SHALL ignore all inputs when in_valid & !in_ready, with no state change.

Reset
REQ-030 SHALL, on reset high at a clk edge, set state EMPTY, out_valid=0, out_data=0, HI=0, LO=0, flags=0, v_sticky=0, op_count=0.
REQ-031 SHALL give reset priority over accept, drain and clr_sticky in the same cycle; a held result mid-handshake is discarded.
REQ-032 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-033 SHALL, with HILO_BYPASS_EN defined, make an accept with FS 1E/1F and rd_sel 01/10 capture the incoming Y_hi/Y_lo into out_data. Without HILO_BYPASS_EN, REQ-025 holds (old HI/LO is returned).

Verification
REQ-034 SHALL cover: reset, then FS=1E, Y_hi=0x1, Y_lo=0x2, rd_sel=00, in_valid 1 cycle, out_ready=1 → next cycle out_valid=1, out_data=0x2, HI=0x1, LO=0x2, op_count=1.
REQ-035 SHALL cover: HI=0xA, then FS=1F, Y_hi=0xB, rd_sel=01 → out_data=0xA without HILO_BYPASS_EN, 0xB with it; HI=0xB in both builds.
REQ-036 SHALL cover: out_ready=0, two back-to-back in_valid (Y_lo 5 then 6) → first accepted, second stalls with in_ready=0, out_data stays 5; out_ready=1 → 6 accepted the same cycle, no bubble.
REQ-037 SHALL cover: accept with V=1 → v_sticky=1; later accept with V=0 → v_sticky still 1; clr_sticky together with a V=1 accept → v_sticky=1; clr_sticky alone → 0.
REQ-038 SHALL cover: op_count preloaded to 0xFFFF via 65535 accepts, plus one accept → 0x0000.
REQ-039 SHALL cover: reset asserted while FULL with out_ready=0 and in_valid=1 → next cycle out_valid=0, all registers 0, in_ready=1.
